// File: rtl/m_dmem_arb.sv
// Round-robin arbiter sharing one single-port data memory between the
// processor port (0) and the loader/debug port (1); one access per cycle.
module m_dmem_arb #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_hold,
  input  logic              w_req0,
  input  logic              w_req1,
  input  logic              w_we0,
  input  logic              w_we1,
  input  logic [ADDR_W-1:0] w_addr0,
  input  logic [ADDR_W-1:0] w_addr1,
  input  logic [DATA_W-1:0] w_wd0,
  input  logic [DATA_W-1:0] w_wd1,
  output logic              r_gnt0,
  output logic              r_gnt1,
  output logic              r_rv0,
  output logic              r_rv1,
  output logic [DATA_W-1:0] r_rd,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic              w_mem_we,
  output logic [DATA_W-1:0] w_mem_din,
  input  logic [DATA_W-1:0] w_mem_dout
);

  // Handshake: a requester holds req/we/addr/wd stable until the cycle its
  // r_gnt is high; at the edge closing that cycle it may drop req or present
  // the next request. While r_gnt is high the requester is ineligible, so a
  // held request is never captured twice. Read data returns one cycle after
  // the grant cycle, qualified by r_rv0/r_rv1.

  // Stage A: the access currently driving memory
  logic              a_v;
  logic              a_id;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wd;
  logic              r_last;

  logic e0;
  logic e1;
  logic cap;
  logic win;

  always_comb begin
    e0  = w_req0 & ~r_gnt0;
    e1  = w_req1 & ~r_gnt1;
    cap = ~w_hold & (e0 | e1);
    win = 1'b0;
    if (e0 && e1) win = ~r_last;
    else if (e1)  win = 1'b1;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      a_v    <= 1'b0;
      a_id   <= 1'b0;
      a_we   <= 1'b0;
      a_addr <= '0;
      a_wd   <= '0;
      r_last <= 1'b1;
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
    end else begin
      a_v    <= cap;
      r_gnt0 <= cap & ~win;
      r_gnt1 <= cap & win;
      if (cap) begin
        a_id   <= win;
        a_we   <= win ? w_we1   : w_we0;
        a_addr <= win ? w_addr1 : w_addr0;
        a_wd   <= win ? w_wd1   : w_wd0;
        r_last <= win;
      end
    end
  end

  // Stage B: capture read data at the edge closing the stage-A cycle
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rv0 <= 1'b0;
      r_rv1 <= 1'b0;
      r_rd  <= '0;
    end else begin
      r_rv0 <= a_v & ~a_we & ~a_id;
      r_rv1 <= a_v & ~a_we & a_id;
      if (a_v && !a_we) r_rd <= w_mem_dout;
    end
  end

  assign w_mem_addr = a_addr;
  assign w_mem_din  = a_wd;
  assign w_mem_we   = a_v & a_we;

endmodule

// File: tb/tb_m_dmem_arb.sv
// Bench for m_dmem_arb: cycle table of requests with expected grants and
// read-valids, a behavioural memory, and a read-data scoreboard.
module tb_m_dmem_arb;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic              rst;
    logic              hold;
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wd0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wd1;
    logic              eg0;
    logic              eg1;
    logic              erv0;
    logic              erv1;
  } vec_t;

  logic              w_clk;
  logic              w_rst_n;
  logic              w_hold;
  logic              w_req0;
  logic              w_req1;
  logic              w_we0;
  logic              w_we1;
  logic [ADDR_W-1:0] w_addr0;
  logic [ADDR_W-1:0] w_addr1;
  logic [DATA_W-1:0] w_wd0;
  logic [DATA_W-1:0] w_wd1;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rv0;
  logic              r_rv1;
  logic [DATA_W-1:0] r_rd;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_din;
  logic [DATA_W-1:0] w_mem_dout;

  logic [DATA_W-1:0] mem  [0:4095];
  logic [DATA_W-1:0] gold [0:4095];
  logic [DATA_W:0]   exp_q[$];
  vec_t              tbl[$];
  vec_t              t;
  logic [DATA_W-1:0] rnd;
  int                n_vec;
  int                n_err;

  m_dmem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_hold(w_hold),
    .w_req0(w_req0), .w_req1(w_req1), .w_we0(w_we0), .w_we1(w_we1),
    .w_addr0(w_addr0), .w_addr1(w_addr1), .w_wd0(w_wd0), .w_wd1(w_wd1),
    .r_gnt0(r_gnt0), .r_gnt1(r_gnt1), .r_rv0(r_rv0), .r_rv1(r_rv1),
    .r_rd(r_rd), .w_mem_addr(w_mem_addr), .w_mem_we(w_mem_we),
    .w_mem_din(w_mem_din), .w_mem_dout(w_mem_dout)
  );

  // Clock / memory model
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) if (w_mem_we) mem[w_mem_addr] <= w_mem_din;
  assign w_mem_dout = mem[w_mem_addr];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Scoreboard: each read-valid pops one {id, data} expectation
  always @(negedge w_clk) begin
    if (w_rst_n && (r_rv0 || r_rv1)) begin
      if (exp_q.size() == 0) begin
        chk("rv_unexpected", {30'd0, r_rv1, r_rv0}, 32'd0);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        chk("rv_tag", {30'd0, r_rv1, r_rv0}, e[DATA_W] ? 32'd2 : 32'd1);
        chk("rd_data", r_rd, e[DATA_W-1:0]);
      end
    end
  end

  task automatic idle_inputs();
    w_hold = 0; w_req0 = 0; w_req1 = 0; w_we0 = 0; w_we1 = 0;
    w_addr0 = '0; w_addr1 = '0; w_wd0 = '0; w_wd1 = '0;
  endtask

  task automatic do_reset();
    w_rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_gnt", {30'd0, r_gnt1, r_gnt0}, 32'd0);
    chk("rst_rv", {30'd0, r_rv1, r_rv0}, 32'd0);
    chk("rst_we", {31'd0, w_mem_we}, 32'd0);
    chk("rst_rd", r_rd, 32'd0);
    @(posedge w_clk); #1;
    w_rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic rst, hold, r0, w0, input logic [ADDR_W-1:0] a0,
                              input logic [DATA_W-1:0] d0, input logic r1, w1,
                              input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                              input logic g0, g1, v0, v1);
    vec_t v;
    v.rst = rst; v.hold = hold;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wd0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wd1 = d1;
    v.eg0 = g0; v.eg1 = g1; v.erv0 = v0; v.erv1 = v1;
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    w_rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4096; i++) begin
      mem[i]  = '0;
      gold[i] = '0;
    end
    mem[1] = 32'd11; gold[1] = 32'd11;
    mem[2] = 32'd22; gold[2] = 32'd22;
    rnd = 32'($urandom_range(32'h7fff_ffff, 1));

    // Write then read-after-write from port 0
    tbl.push_back(mk(H,L, H,H,12'd5,32'hDEADBEEF, L,L,12'd0,32'd0, H,L,L,L));
    tbl.push_back(mk(L,L, H,L,12'd5,32'd0,        L,L,12'd0,32'd0, L,L,L,L));
    tbl.push_back(mk(L,L, H,L,12'd5,32'd0,        L,L,12'd0,32'd0, H,L,L,L));
    tbl.push_back(mk(L,L, L,L,12'd0,32'd0,        L,L,12'd0,32'd0, L,L,H,L));
    tbl.push_back(mk(L,L, L,L,12'd0,32'd0,        L,L,12'd0,32'd0, L,L,L,L));
    // Both ports reading continuously: strict alternation starting at 0
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk((k == 0) ? H : L, L, H,L,12'd1,32'd0, H,L,12'd2,32'd0,
                       (k % 2 == 0) ? H : L, (k % 2 == 1) ? H : L,
                       (k % 2 == 1) ? H : L, (k > 0 && k % 2 == 0) ? H : L));
    tbl.push_back(mk(L,L, L,L,12'd0,32'd0, L,L,12'd0,32'd0, L,L,L,H));
    tbl.push_back(mk(L,L, L,L,12'd0,32'd0, L,L,12'd0,32'd0, L,L,L,L));
    // Port 1 alone held: one grant every other cycle
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(L,L, L,L,12'd0,32'd0, H,L,12'd2,32'd0,
                       L, (k % 2 == 0) ? H : L, L, (k % 2 == 1) ? H : L));
    tbl.push_back(mk(L,L, L,L,12'd0,32'd0, L,L,12'd0,32'd0, L,L,L,L));
    // Hold with both pending, then write from 0 and read-back from 1
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(L,H, H,H,12'd9,rnd, H,L,12'd9,32'd0, L,L,L,L));
    tbl.push_back(mk(L,L, H,H,12'd9,rnd,    H,L,12'd9,32'd0, H,L,L,L));
    tbl.push_back(mk(L,L, L,L,12'd0,32'd0,  H,L,12'd9,32'd0, L,H,L,L));
    tbl.push_back(mk(L,L, L,L,12'd0,32'd0,  L,L,12'd0,32'd0, L,L,L,H));
    tbl.push_back(mk(L,L, L,L,12'd0,32'd0,  L,L,12'd0,32'd0, L,L,L,L));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      if (t.rst) do_reset();
      w_hold = t.hold;
      w_req0 = t.req0; w_we0 = t.we0; w_addr0 = t.addr0; w_wd0 = t.wd0;
      w_req1 = t.req1; w_we1 = t.we1; w_addr1 = t.addr1; w_wd1 = t.wd1;
      if (t.eg0) begin
        if (t.we0) gold[t.addr0] = t.wd0;
        else exp_q.push_back({1'b0, gold[t.addr0]});
      end
      if (t.eg1) begin
        if (t.we1) gold[t.addr1] = t.wd1;
        else exp_q.push_back({1'b1, gold[t.addr1]});
      end
      @(posedge w_clk); #1;
      chk($sformatf("v%0d_gnt0", i), {31'd0, r_gnt0}, {31'd0, t.eg0});
      chk($sformatf("v%0d_gnt1", i), {31'd0, r_gnt1}, {31'd0, t.eg1});
      chk($sformatf("v%0d_mem_we", i), {31'd0, w_mem_we},
          {31'd0, (t.eg0 & t.we0) | (t.eg1 & t.we1)});
      chk($sformatf("v%0d_rv0", i), {31'd0, r_rv0}, {31'd0, t.erv0});
      chk($sformatf("v%0d_rv1", i), {31'd0, r_rv1}, {31'd0, t.erv1});
      if (t.eg0) chk($sformatf("v%0d_addr", i), {20'd0, w_mem_addr}, {20'd0, t.addr0});
      if (t.eg1) chk($sformatf("v%0d_addr", i), {20'd0, w_mem_addr}, {20'd0, t.addr1});
      if (t.eg0 && t.we0) chk($sformatf("v%0d_din", i), w_mem_din, t.wd0);
      if (i == 1) chk("mem5_written", mem[5], 32'hDEADBEEF);
    end

    // Asynchronous reset in the middle of a granted write to addr 7
    do_reset();
    w_req0 = 1; w_we0 = 1; w_addr0 = 12'd7; w_wd0 = 32'h0000_0077;
    @(posedge w_clk); #1;
    chk("mid_gnt0", {31'd0, r_gnt0}, 32'd1);
    chk("mid_we", {31'd0, w_mem_we}, 32'd1);
    #2;
    w_rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("mid_we_drop", {31'd0, w_mem_we}, 32'd0);
    chk("mid_gnt_drop", {30'd0, r_gnt1, r_gnt0}, 32'd0);
    chk("mid_rv_drop", {30'd0, r_rv1, r_rv0}, 32'd0);
    @(posedge w_clk); #1;
    chk("mem7_kept", mem[7], gold[7]);
    w_rst_n = 1'b1;
    w_req0 = 1; w_addr0 = 12'd7;
    w_req1 = 1; w_addr1 = 12'd7;
    exp_q.push_back({1'b0, gold[7]});
    @(posedge w_clk); #1;
    chk("post_rst_gnt0", {30'd0, r_gnt1, r_gnt0}, 32'd1);
    w_req0 = 0;
    exp_q.push_back({1'b1, gold[7]});
    @(posedge w_clk); #1;
    chk("post_rst_gnt1", {30'd0, r_gnt1, r_gnt0}, 32'd2);
    chk("post_rst_rv0", {30'd0, r_rv1, r_rv0}, 32'd1);
    idle_inputs();
    repeat (3) @(posedge w_clk);
    #1;
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/m_dmem_arb.md
# m_dmem_arb

Two-port round-robin arbiter that shares the single-port 4K-word data memory (m_amemory) between requester 0 (processor load/store port) and requester 1 (loader/debug port that fills or dumps data memory). It registers one winning request per cycle, drives the memory address, write-enable and write-data lines from that register for exactly one cycle, and returns registered read data tagged to the winning requester. It sits between the requesters and m_amemory, and it is the only block that drives the memory's address, write-enable and write-data inputs.

## Interface
- ADDR_W, 12, word address width (matches m_amemory w_addr)
- DATA_W, 32, data width
- w_clk  in  1  clock; all state changes on rising edge
- w_rst_n  in  1  reset; asynchronous, active-low
- w_hold  in  1  when 1, no new request is captured (in-flight access completes)
- w_req0, w_req1  in  1 each  request valid
- w_we0, w_we1  in  1 each  1 = write, 0 = read
- w_addr0, w_addr1  in  ADDR_W each  word address
- w_wd0, w_wd1  in  DATA_W each  write data
- r_gnt0, r_gnt1  out  1 each  registered; 1 during the cycle the requester's access drives memory
- r_rv0, r_rv1  out  1 each  registered read-valid pulse
- r_rd  out  DATA_W  registered read data (shared; qualified by r_rv0/r_rv1)
- w_mem_addr  out  ADDR_W  to memory address
- w_mem_we  out  1  to memory write enable
- w_mem_din  out  DATA_W  to memory write data
- w_mem_dout  in  DATA_W  combinational read data from memory

## Operation
- Stage A register holds: a_v, a_id, a_we, a_addr, a_wd. Memory outputs come combinationally from stage A only: w_mem_addr=a_addr, w_mem_din=a_wd, w_mem_we=a_v&a_we.
- Eligibility at each edge: e0 = w_req0 & ~r_gnt0; e1 = w_req1 & ~r_gnt1. A requester whose grant is high in the current cycle is not eligible at the closing edge, so the same request is never captured twice.
- Requester protocol: hold req, we, addr and wd stable until the cycle r_gnt is high, then drop req, or present the next request, at that edge. The next request from the same requester is captured one edge later at the earliest.
- Winner selection, evaluated only when w_hold = 0:
  - neither eligible: a_v <= 0.
  - one eligible: that requester wins.
  - both eligible: the requester not equal to r_last wins.
- On capture: a_v <= 1, a_id <= winner, stage A loaded from the winner's inputs, r_last <= winner, r_gnt[winner] <= 1, other grant <= 0. With no capture, both grants <= 0.
- w_hold = 1: a_v <= 0 and grants <= 0. r_last is unchanged.
- Stage B, at the edge closing a stage-A cycle with a_v=1 and a_we=0: r_rd <= w_mem_dout, r_rv[a_id] <= 1. Otherwise both r_rv <= 0 and r_rd holds its value.
- Writes commit in the memory at the edge closing the stage-A cycle. A read in the following cycle to the same address returns the new data.
- Address and data pass through at full width; the arbiter does no wrap or range check.

## Timing
- Reset (w_rst_n=0, asynchronous) clears a_v, r_gnt0, r_gnt1, r_rv0 and r_rv1 to 0; r_rd and a_addr/a_wd to 0; r_last to 1, so requester 0 wins the first tie. w_mem_we falls to 0 immediately.
- Reset mid-access: the in-flight write is dropped if reset asserts before its commit edge. The in-flight read produces no r_rv.
- Latency, request sampled at edge k:
  - grant high and memory driven in cycle k..k+1.
  - a write commits at edge k+1.
  - read data and r_rv are valid in cycle k+1..k+2.
- Throughput: one access per cycle in aggregate. With both requesters continuously requesting, grants alternate 0,1,0,1.
- A single requester issuing back-to-back requests gets at most one grant every 2 cycles.
- Simultaneous events:
  - a new capture at the same edge that stage B completes a read is allowed; the pipeline stages are independent.
  - w_hold asserted at the same edge as a request: no capture, and the request stays pending.

## Test plan
- Reset, then req0 alone: write addr 5, data 32'hDEADBEEF at edge 1. Required: r_gnt0 high in cycle 1-2, w_mem_we=1 in that cycle only, memory[5]=DEADBEEF after edge 2.
- Read-after-write: req0 reads addr 5 immediately after the write above. Required: r_rv0 pulses exactly one cycle with r_rd=32'hDEADBEEF, 2 cycles after its req was sampled; r_rv1 stays 0.
- Both requesters held high for 8 edges, reads to addr 1 and addr 2 holding 11 and 22. Required: first grant to requester 0, grants strictly alternating, r_rd alternating 11/22 tagged by the matching r_rv.
- req1 alone held continuously for 6 edges. Required: r_gnt1 pattern 1,0,1,0,1,0; no double capture; 3 read pulses.
- w_hold=1 for 3 cycles with req0 and req1 pending. Required: no grants and w_mem_we=0 throughout; on release, requester 0 is granted if r_last=1.
- Reset pulsed low asynchronously mid-cycle during a granted write to addr 7 (old value 0). Required: w_mem_we and all grants/r_rv drop at once, memory[7] stays 0, and the first grant after reset goes to requester 0.
